micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 4, meaning return-stack entries (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, begin microprogram execution from address 0.
REQ-005 SHALL have port stall, input, 1, hold all state for this cycle.
REQ-006 SHALL have port mir_next, input, 8, next-address field of the current microword.
REQ-007 SHALL have port mir_seq, input, 3, sequencing code of the current microword.
REQ-008 SHALL have port ir, input, 8, instruction register, used as the dispatch target.
REQ-009 SHALL have port z, input, 1, ALU zero flag.
REQ-010 SHALL have port upc, output, 8, micro-PC, i.e. the control-store address.
REQ-011 SHALL have port running, output, 1, high in RUN.
REQ-012 SHALL have port halted, output, 1, high in HALT.
REQ-013 SHALL have port fault, output, 1, high in FAULT.
REQ-014 SHALL have port sp, output, 4, current return-stack occupancy.

Function
REQ-015 SHALL implement states IDLE, RUN, HALT and FAULT, encoded one-hot or binary (free choice).
REQ-016 IDLE: upc holds 0; start=1 moves to RUN with upc=0 and sp=0.
REQ-017 In RUN with stall=0, SHALL compute the next upc from mir_seq, sampling mir_next, ir and z in the same cycle:
- 000 NEXT -> upc+1
- 001 GOTO -> mir_next
- 010 DISPATCH -> ir
- 011 BRZ -> z ? mir_next : upc+1
- 100 BRNZ -> z ? upc+1 : mir_next
- 101 CALL -> push upc+1, then mir_next
- 110 RET -> pop top of stack into upc
- 111 HALT -> upc held, go to HALT
REQ-018 upc+1 SHALL wrap modulo 256 (255 -> 0), both as a next address and as a pushed value.
REQ-019 Latency: the new upc SHALL be visible one rising edge after the microword that requested it; the control store presents the microword for upc combinationally.
REQ-020 Stack SHALL be LIFO, STACK_DEPTH x 8 bits; sp increments on CALL and decrements on RET.
REQ-021 CALL with sp==STACK_DEPTH SHALL NOT push, SHALL hold upc, and SHALL go to FAULT.
REQ-022 RET with sp==0 SHALL hold upc and go to FAULT.
REQ-023 stall=1 in RUN SHALL freeze upc, sp, the stack contents and the state, overriding every mir_seq code including HALT.
REQ-024 start SHALL be ignored in RUN and in FAULT.
REQ-025 HALT: upc and stack are held; start=1 returns to RUN with upc=0 and sp=0.
REQ-026 FAULT: upc is held, and the state SHALL be left only by rst.
REQ-027 running, halted and fault SHALL be registered, mutually exclusive, and all low in IDLE.
REQ-028 In IDLE, HALT and FAULT, mir_seq, mir_next, ir and z SHALL have no effect.

Reset
REQ-029 rst=1 SHALL immediately, without a clock edge, force IDLE, upc=0, sp=0, running=0, halted=0 and fault=0.
REQ-030 Stack entry contents need not be cleared, but SHALL never be read while sp==0.
REQ-031 rst asserted mid-CALL or mid-RET SHALL leave no partial push or pop once rst is released.
REQ-032 After rst deasserts, the block SHALL stay in IDLE until start.

Verification
REQ-033 Sequential walk: reset, start, mir_seq=000 for 300 cycles -> upc = 0,1,...,255,0,1,...; running=1 throughout.
REQ-034 Branches and dispatch:
- upc=5, BRZ, mir_next=40, z=1 -> upc=40
- repeat with z=0 -> upc=6
- DISPATCH with ir=0x2E -> upc=46
REQ-035 Nested calls:
- CALL at upc=10 to 20 -> upc=20, sp=1
- CALL at upc=20 to 30 -> upc=30, sp=2
- RET -> upc=21, sp=1
- RET -> upc=11, sp=0
REQ-036 Stack faults:
- 5 CALLs with STACK_DEPTH=4 -> the 5th gives fault=1, sp=4, upc frozen
- fresh run, RET at sp=0 -> fault=1
- start ignored in FAULT; only rst clears fault
REQ-037 Stall and HALT:
- stall=1 with mir_seq=101 for 3 cycles -> upc and sp unchanged
- HALT at upc=53 -> halted=1, upc=53
- start -> upc=0, running=1
REQ-038 Asynchronous reset: rst pulsed between clock edges while in RUN at upc=77 -> upc=0 and state IDLE before the next edge.

Source files
------------

// File: rtl/micro_sequencer.sv
// ---------------------------------------------------------------------------
// micro_sequencer
//
// Micro-program sequencer. It computes the next micro-PC (control-store
// address) from the sequencing code of the current microword and keeps a
// small LIFO return stack for micro-subroutine calls.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst          : asynchronous active-high reset (forces IDLE, upc=0, sp=0)
//   start        : begin execution at address 0 (honoured in IDLE and HALT)
//   stall        : freeze every piece of state for this cycle while in RUN
//   mir_next     : next-address field of the current microword
//   mir_seq      : sequencing code of the current microword
//   ir           : instruction register, target of DISPATCH
//   z            : ALU zero flag, condition for BRZ / BRNZ
//   upc          : micro-PC
//   running      : registered, high in RUN
//   halted       : registered, high in HALT
//   fault        : registered, high in FAULT
//   sp           : return-stack occupancy (0..STACK_DEPTH)
//   o_dbg_state  : current FSM state (IDLE=0, RUN=1, HALT=2, FAULT=3)
//
// Flow control: there is no valid/ready handshake. While in RUN with
// stall low, exactly one microword (mir_seq/mir_next/ir/z as presented
// for the current upc) is consumed on every rising edge; with stall high
// nothing is consumed and nothing changes.
// ---------------------------------------------------------------------------
module micro_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stall,
    input  logic [7:0] mir_next,
    input  logic [2:0] mir_seq,
    input  logic [7:0] ir,
    input  logic       z,
    output logic [7:0] upc,
    output logic       running,
    output logic       halted,
    output logic       fault,
    output logic [3:0] sp,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [2:0] SEQ_NEXT     = 3'b000;
    localparam logic [2:0] SEQ_GOTO     = 3'b001;
    localparam logic [2:0] SEQ_DISPATCH = 3'b010;
    localparam logic [2:0] SEQ_BRZ      = 3'b011;
    localparam logic [2:0] SEQ_BRNZ     = 3'b100;
    localparam logic [2:0] SEQ_CALL     = 3'b101;
    localparam logic [2:0] SEQ_RET      = 3'b110;
    localparam logic [2:0] SEQ_HALT     = 3'b111;

    // Index width matches the stack array size so entry selection is exact.
    localparam int         IDXW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(STACK_DEPTH);

    state_t          r_state;
    logic [7:0]      r_upc;
    logic [3:0]      r_sp;
    logic            r_running;
    logic            r_halted;
    logic            r_fault;
    logic [7:0]      r_stack [STACK_DEPTH];

    logic [7:0]      w_upc_inc;
    logic [3:0]      w_sp_dec;
    logic            w_full;
    logic            w_empty;
    logic            w_active;
    logic            w_push;
    logic [IDXW-1:0] w_push_idx;
    logic [IDXW-1:0] w_top_idx;
    logic [7:0]      w_top;

    // 8-bit add wraps 255 -> 0 naturally, for both branch and push values.
    assign w_upc_inc  = r_upc + 8'd1;
    assign w_sp_dec   = r_sp - 4'd1;
    assign w_full     = (r_sp == DEPTH_L);
    assign w_empty    = (r_sp == 4'd0);
    assign w_active   = (r_state == ST_RUN) && !stall;
    assign w_push_idx = r_sp[IDXW-1:0];
    assign w_top_idx  = w_sp_dec[IDXW-1:0];
    // Only consumed on a RET with sp != 0, so an empty stack is never used.
    assign w_top      = r_stack[w_top_idx];

    // Gating with rst means a reset coinciding with a CALL edge writes nothing.
    assign w_push = w_active && (mir_seq == SEQ_CALL) && !w_full && !rst;

    // Stack storage carries no reset: entries above sp are never read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_upc_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_upc     <= 8'd0;
            r_sp      <= 4'd0;
            r_running <= 1'b0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    // upc is already 0 in IDLE; in HALT it holds until start.
                    if (start) begin
                        r_state   <= ST_RUN;
                        r_upc     <= 8'd0;
                        r_sp      <= 4'd0;
                        r_running <= 1'b1;
                        r_halted  <= 1'b0;
                        r_fault   <= 1'b0;
                    end
                end

                ST_RUN: begin
                    if (w_active) begin
                        case (mir_seq)
                            SEQ_NEXT:     r_upc <= w_upc_inc;
                            SEQ_GOTO:     r_upc <= mir_next;
                            SEQ_DISPATCH: r_upc <= ir;
                            SEQ_BRZ:      r_upc <= z ? mir_next : w_upc_inc;
                            SEQ_BRNZ:     r_upc <= z ? w_upc_inc : mir_next;
                            SEQ_CALL: begin
                                if (w_full) begin
                                    r_state   <= ST_FAULT;
                                    r_running <= 1'b0;
                                    r_fault   <= 1'b1;
                                end else begin
                                    r_sp  <= r_sp + 4'd1;
                                    r_upc <= mir_next;
                                end
                            end
                            SEQ_RET: begin
                                if (w_empty) begin
                                    r_state   <= ST_FAULT;
                                    r_running <= 1'b0;
                                    r_fault   <= 1'b1;
                                end else begin
                                    r_sp  <= w_sp_dec;
                                    r_upc <= w_top;
                                end
                            end
                            SEQ_HALT: begin
                                r_state   <= ST_HALT;
                                r_running <= 1'b0;
                                r_halted  <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_FAULT: begin
                    // Sticky: only rst leaves this state.
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign upc         = r_upc;
    assign sp          = r_sp;
    assign running     = r_running;
    assign halted      = r_halted;
    assign fault       = r_fault;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 15;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_HALT  = 2;
  localparam int M_FAULT = 3;

  localparam logic [2:0] S_NEXT = 3'd0, S_GOTO = 3'd1, S_DISP = 3'd2, S_BRZ = 3'd3;
  localparam logic [2:0] S_BRNZ = 3'd4, S_CALL = 3'd5, S_RET = 3'd6, S_HALT = 3'd7;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stall;
  logic [7:0] mir_next;
  logic [2:0] mir_seq;
  logic [7:0] ir;
  logic       z;
  logic [7:0] upc;
  logic       running;
  logic       halted;
  logic       fault;
  logic [3:0] sp;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  micro_sequencer #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stall(stall),
    .mir_next(mir_next),
    .mir_seq(mir_seq),
    .ir(ir),
    .z(z),
    .upc(upc),
    .running(running),
    .halted(halted),
    .fault(fault),
    .sp(sp),
    .o_dbg_state(dbg_state)
  );

  logic [W-1:0] dut_vec;
  assign dut_vec = {upc, sp, running, halted, fault};

  // ---------------- reference model ----------------
  int         m_mode;
  logic [7:0] m_upc;
  logic [7:0] m_stack[$];

  function automatic logic [W-1:0] model_vec();
    return {m_upc, 4'(m_stack.size()), m_mode == M_RUN, m_mode == M_HALT, m_mode == M_FAULT};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE;
    m_upc  = 8'd0;
    m_stack.delete();
  endtask

  task automatic model_step(input logic st, input logic stl, input logic [2:0] seq,
                            input logic [7:0] nxt, input logic [7:0] irv, input logic zv);
    logic [7:0] inc;
    inc = 8'((int'(m_upc) + 1) % 256);
    case (m_mode)
      M_IDLE, M_HALT: begin
        if (st) begin
          m_mode = M_RUN;
          m_upc  = 8'd0;
          m_stack.delete();
        end
      end
      M_RUN: begin
        if (!stl) begin
          case (seq)
            S_NEXT: m_upc = inc;
            S_GOTO: m_upc = nxt;
            S_DISP: m_upc = irv;
            S_BRZ:  m_upc = zv ? nxt : inc;
            S_BRNZ: m_upc = zv ? inc : nxt;
            S_CALL: begin
              if (m_stack.size() == DEPTH) m_mode = M_FAULT;
              else begin
                m_stack.push_back(inc);
                m_upc = nxt;
              end
            end
            S_RET: begin
              if (m_stack.size() == 0) m_mode = M_FAULT;
              else m_upc = m_stack.pop_back();
            end
            default: m_mode = M_HALT;
          endcase
        end
      end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           vectors     = 0;
  int           miscompares = 0;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got upc=%0d sp=%0d run/halt/fault=%b, expected upc=%0d sp=%0d run/halt/fault=%b",
               nm, act[14:7], act[6:3], act[2:0], exp[14:7], exp[6:3], exp[2:0]);
    end
  endtask

  // Monitor: the DUT presents a new micro-PC after every rising edge.
  initial begin
    logic [W-1:0] e;
    string        n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, dut_vec, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic st, input logic stl, input logic [2:0] seq,
                       input logic [7:0] nxt, input string nm);
    logic [7:0] irv;
    logic       zv;
    irv = 8'($urandom);
    zv  = 1'($urandom);
    drive_full(st, stl, seq, nxt, irv, zv, nm);
  endtask

  task automatic drive_full(input logic st, input logic stl, input logic [2:0] seq,
                            input logic [7:0] nxt, input logic [7:0] irv, input logic zv,
                            input string nm);
    @(negedge clk);
    start    = st;
    stall    = stl;
    mir_seq  = seq;
    mir_next = nxt;
    ir       = irv;
    z        = zv;
    model_step(st, stl, seq, nxt, irv, zv);
    exp_q.push_back(model_vec());
    name_q.push_back(nm);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'($urandom);
    stall    = 1'($urandom);
    mir_seq  = 3'($urandom);
    mir_next = 8'($urandom);
    #2;
    model_reset();
    check("reset_state", dut_vec, model_vec());
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    mir_seq = 3'd0; mir_next = 8'd0; ir = 8'd0; z = 1'b0;
    model_reset();
    do_reset();

    // IDLE ignores everything but start
    for (int i = 0; i < 4; i++)
      drive(1'b0, 1'($urandom), 3'($urandom), 8'($urandom), "idle_hold");
    drive(1'b1, 1'b0, S_NEXT, 8'd0, "start");

    // sequential walk with wrap
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1) & 1'b0), 1'b0, S_NEXT, 8'($urandom), "walk");

    // branches and dispatch
    drive(1'b0, 1'b0, S_GOTO, 8'd5, "goto5");
    drive_full(1'b0, 1'b0, S_BRZ, 8'd40, 8'($urandom), 1'b1, "brz_taken");
    drive(1'b0, 1'b0, S_GOTO, 8'd5, "goto5b");
    drive_full(1'b0, 1'b0, S_BRZ, 8'd40, 8'($urandom), 1'b0, "brz_not_taken");
    drive_full(1'b0, 1'b0, S_BRNZ, 8'd90, 8'($urandom), 1'b0, "brnz_taken");
    drive_full(1'b0, 1'b0, S_BRNZ, 8'd90, 8'($urandom), 1'b1, "brnz_not_taken");
    drive_full(1'b0, 1'b0, S_DISP, 8'($urandom), 8'h2E, 1'($urandom), "dispatch");

    // nested calls
    drive(1'b0, 1'b0, S_GOTO, 8'd10, "goto10");
    drive(1'b0, 1'b0, S_CALL, 8'd20, "call20");
    drive(1'b0, 1'b0, S_CALL, 8'd30, "call30");
    drive(1'b0, 1'b0, S_RET, 8'($urandom), "ret_inner");
    drive(1'b0, 1'b0, S_RET, 8'($urandom), "ret_outer");

    // stall overrides every code, including HALT
    drive(1'b0, 1'b0, S_CALL, 8'd70, "call70");
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, S_CALL, 8'($urandom), "stall_call");
    drive(1'b0, 1'b1, S_HALT, 8'($urandom), "stall_halt");
    drive(1'b0, 1'b1, S_RET, 8'($urandom), "stall_ret");
    drive(1'b0, 1'b0, S_RET, 8'($urandom), "ret_after_stall");

    // HALT and restart
    drive(1'b0, 1'b0, S_GOTO, 8'd53, "goto53");
    drive(1'b0, 1'b0, S_HALT, 8'($urandom), "halt53");
    drive(1'b0, 1'($urandom), 3'($urandom), 8'($urandom), "halt_hold");
    drive(1'b1, 1'b0, 3'($urandom), 8'($urandom), "restart");

    // stack overflow
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0, S_CALL, 8'($urandom), "call_overflow");
    drive(1'b1, 1'b0, S_NEXT, 8'($urandom), "fault_ignores_start");
    drive(1'b0, 1'b0, S_RET, 8'($urandom), "fault_ignores_ret");
    do_reset();

    // stack underflow
    drive(1'b1, 1'b0, S_NEXT, 8'd0, "start_u");
    drive(1'b0, 1'b0, S_RET, 8'($urandom), "ret_underflow");
    drive(1'b1, 1'b0, S_GOTO, 8'($urandom), "fault_ignores_start2");
    do_reset();

    // push value wraps 255 -> 0
    drive(1'b1, 1'b0, S_NEXT, 8'd0, "start_w");
    drive(1'b0, 1'b0, S_GOTO, 8'd255, "goto255");
    drive(1'b0, 1'b0, S_CALL, 8'd100, "call_at_255");
    drive(1'b0, 1'b0, S_RET, 8'($urandom), "ret_to_0");

    // randomized run
    for (int i = 0; i < 400; i++) begin
      logic [2:0] seq;
      if (m_mode == M_FAULT) begin
        do_reset();
        drive(1'b1, 1'b0, S_NEXT, 8'($urandom), "rand_start");
      end else begin
        seq = 3'($urandom_range(0, 7));
        if (seq == S_HALT && $urandom_range(0, 3) != 0) seq = S_NEXT;
        drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 4) == 0),
              seq, 8'($urandom), "random");
      end
    end

    // asynchronous reset between edges at upc=77
    do_reset();
    drive(1'b1, 1'b0, S_NEXT, 8'd0, "start_a");
    drive(1'b0, 1'b0, S_GOTO, 8'd77, "goto77");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_77", dut_vec, model_vec());
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL async_rst_state: got state=%0d, expected IDLE(0)", dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'($urandom), 3'($urandom), 8'($urandom), "idle_after_rst");

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
